// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF     = 3;
  localparam int DRAIN_CYC_DEF = 3;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_FLUSH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HALT  = 3'd3
  } state_t;

endpackage

// File: rtl/cntdown_reg.sv
// Loadable down-counter with enable-gated decrement that saturates at zero.
module cntdown_reg #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stalls, branch-squash countdown, serializing drain and halt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mispredict,
  input  logic [CNT_W-1:0] flush_amt,
  input  logic             load_use,
  input  logic             mem_busy,
  input  logic             syscall_ex,
  input  logic             halt_req,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             id_kill,
  output logic             ex_kill,
  output logic             flush,
  output logic             halted,
  output logic [2:0]       state_o
);

  state_t           state, state_nxt;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             halt_lat, halt_load;

  cntdown_reg #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Zero is also treated as terminal so a countdown can never get stuck.
  assign cnt_last = (cnt == CNT_W'(1)) || cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      halt_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      if (halt_load) halt_lat <= halt_req;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    halt_load = 1'b0;
    if ((state != ST_HALT) && !mem_busy) begin
      case (state)
        ST_FLUSH: begin
          cnt_dec = 1'b1;
          if (cnt_last) state_nxt = ST_RUN;
        end
        ST_DRAIN: begin
          cnt_dec = 1'b1;
          if (cnt_last) state_nxt = halt_lat ? ST_HALT : ST_RUN;
        end
        default: begin
          if (mispredict) begin
            cnt_load  = 1'b1;
            cnt_val   = (flush_amt == '0) ? CNT_W'(1) : flush_amt;
            state_nxt = ST_FLUSH;
          end else if (syscall_ex) begin
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(DRAIN_CYC);
            halt_load = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end
      endcase
    end
  end

  always_comb begin
    if_en   = 1'b1;
    id_en   = 1'b1;
    ex_en   = 1'b1;
    mem_en  = 1'b1;
    wb_en   = 1'b1;
    id_kill = 1'b0;
    ex_kill = 1'b0;
    flush   = (state == ST_FLUSH);
    halted  = 1'b0;
    if ((state == ST_HALT) || mem_busy) begin
      {if_en, id_en, ex_en, mem_en, wb_en} = 5'b00000;
      halted = (state == ST_HALT);
    end else begin
      case (state)
        ST_FLUSH: id_kill = 1'b1;
        ST_DRAIN: begin
          {if_en, id_en, ex_en} = 3'b000;
          ex_kill = 1'b1;
        end
        default: begin
          if (mispredict) begin
            id_kill = 1'b1;
          end else if (syscall_ex || load_use) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            ex_kill = 1'b1;
          end
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a behavioural reference model and per-cycle compare.
module tb_pipe_ctrl;

  localparam int DRAIN = 3;

  // Output vector order: {if,id,ex,mem,wb, id_kill,ex_kill,flush,halted, state}
  localparam logic [11:0] V_RUN   = 12'b11111_0000_000;
  localparam logic [11:0] V_MISP  = 12'b11111_1000_000;
  localparam logic [11:0] V_STALL = 12'b00111_0100_000;
  localparam logic [11:0] V_FLUSH = 12'b11111_1010_001;
  localparam logic [11:0] V_FRZ_F = 12'b00000_0010_001;
  localparam logic [11:0] V_FRZ_R = 12'b00000_0000_000;
  localparam logic [11:0] V_DRAIN = 12'b00011_0100_010;
  localparam logic [11:0] V_FRZ_D = 12'b00000_0000_010;
  localparam logic [11:0] V_HALT  = 12'b00000_0001_011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mispredict = 1'b0;
  logic [2:0] flush_amt = 3'd0;
  logic       load_use = 1'b0;
  logic       mem_busy = 1'b0;
  logic       syscall_ex = 1'b0;
  logic       halt_req = 1'b0;
  logic       if_en, id_en, ex_en, mem_en, wb_en;
  logic       id_kill, ex_kill, flush, halted;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mispredict (mispredict),
    .flush_amt  (flush_amt),
    .load_use   (load_use),
    .mem_busy   (mem_busy),
    .syscall_ex (syscall_ex),
    .halt_req   (halt_req),
    .if_en      (if_en),
    .id_en      (id_en),
    .ex_en      (ex_en),
    .mem_en     (mem_en),
    .wb_en      (wb_en),
    .id_kill    (id_kill),
    .ex_kill    (ex_kill),
    .flush      (flush),
    .halted     (halted),
    .state_o    (state_o)
  );

  wire [11:0] dut_vec = {if_en, id_en, ex_en, mem_en, wb_en,
                         id_kill, ex_kill, flush, halted, state_o};

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=run 1=flush 2=drain 3=halt, cycles left in countdown.
  int   mode   = 0;
  int   left   = 0;
  logic hlatch = 1'b0;

  logic        chk_en  = 1'b0;
  logic        mid_chk = 1'b0;
  logic        lit_on  = 1'b0;
  logic [11:0] lit_exp = 12'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode   <= 0;
      left   <= 0;
      hlatch <= 1'b0;
    end else if (mode != 3 && !mem_busy) begin
      if (mode == 0) begin
        if (mispredict) begin
          mode <= 1;
          left <= (flush_amt == 3'd0) ? 1 : int'(flush_amt);
        end else if (syscall_ex) begin
          mode   <= 2;
          left   <= DRAIN;
          hlatch <= halt_req;
        end
      end else if (left <= 1) begin
        mode <= (mode == 2 && hlatch) ? 3 : 0;
        left <= 0;
      end else begin
        left <= left - 1;
      end
    end
  end

  function automatic logic [11:0] model_out();
    logic [2:0] st;
    logic       fl;
    st = 3'(mode);
    fl = (mode == 1);
    if (mode == 3) return V_HALT;
    if (mem_busy) return {5'b00000, 2'b00, fl, 1'b0, st};
    if (mode == 1) return V_FLUSH;
    if (mode == 2) return V_DRAIN;
    if (mispredict) return V_MISP;
    if (syscall_ex || load_use) return V_STALL;
    return V_RUN;
  endfunction

  always @(negedge clk or posedge mid_chk) begin
    if (chk_en) begin
      total = total + 1;
      if (dut_vec !== model_out()) begin
        bad = bad + 1;
        $display("FAIL model t=%0t got=%b want=%b", $time, dut_vec, model_out());
      end
      if (lit_on) begin
        total = total + 1;
        if (dut_vec !== lit_exp) begin
          bad = bad + 1;
          $display("FAIL literal t=%0t got=%b want=%b", $time, dut_vec, lit_exp);
        end
      end
    end
  end

  task automatic cyc(input logic mp, input logic [2:0] fa, input logic lu,
                     input logic mb, input logic sc, input logic hr,
                     input logic [11:0] le);
    mispredict = mp;
    flush_amt  = fa;
    load_use   = lu;
    mem_busy   = mb;
    syscall_ex = sc;
    halt_req   = hr;
    lit_exp    = le;
    lit_on     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges and check outputs before the next edge.
  task automatic mid_reset();
    mispredict = 1'b0;
    flush_amt  = 3'd0;
    load_use   = 1'b0;
    mem_busy   = 1'b0;
    syscall_ex = 1'b0;
    halt_req   = 1'b0;
    #1 rst = 1'b1;
    #1;
    lit_exp = V_RUN;
    lit_on  = 1'b1;
    mid_chk = 1'b1;
    #1;
    mid_chk = 1'b0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    lit_exp = V_RUN;
    lit_on  = 1'b1;
    chk_en  = 1'b1;
    mid_chk = 1'b1;
    #1 mid_chk = 1'b0;
    #8 rst = 1'b0;
    @(posedge clk);
    #1;

    // mispredict with flush_amt=2
    cyc(1, 2, 0, 0, 0, 0, V_MISP);
    cyc(0, 0, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // load-use stall, then mispredict beating load-use
    cyc(0, 0, 1, 0, 0, 0, V_STALL);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);
    cyc(1, 1, 1, 0, 0, 0, V_MISP);
    cyc(0, 0, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // memory freeze mid-flush, mispredict ignored while flushing
    cyc(1, 2, 0, 0, 0, 0, V_MISP);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, V_FRZ_F);
    cyc(1, 5, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // flush_amt=0 acts as 1
    cyc(1, 0, 0, 0, 0, 0, V_MISP);
    cyc(0, 0, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // priority: mem_busy over all, mispredict over syscall
    cyc(1, 3, 1, 1, 1, 1, V_FRZ_R);
    cyc(1, 1, 0, 0, 1, 1, V_MISP);
    cyc(0, 0, 0, 0, 0, 0, V_FLUSH);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // syscall without halt, freeze inside drain, back to run
    cyc(0, 0, 1, 0, 1, 0, V_STALL);
    cyc(0, 0, 0, 1, 0, 0, V_FRZ_D);
    cyc(1, 4, 1, 0, 0, 0, V_DRAIN);
    cyc(0, 0, 0, 0, 0, 0, V_DRAIN);
    cyc(0, 0, 0, 0, 0, 0, V_DRAIN);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // syscall with halt: three drain cycles then stuck in halt
    cyc(0, 0, 0, 0, 1, 1, V_STALL);
    cyc(0, 0, 0, 0, 0, 0, V_DRAIN);
    cyc(0, 0, 0, 0, 0, 0, V_DRAIN);
    cyc(0, 0, 0, 0, 0, 0, V_DRAIN);
    cyc(0, 0, 0, 0, 0, 0, V_HALT);
    cyc(0, 0, 0, 1, 0, 0, V_HALT);
    cyc(1, 2, 0, 0, 0, 0, V_HALT);
    cyc(0, 0, 1, 0, 1, 1, V_HALT);
    cyc(0, 0, 0, 0, 0, 0, V_HALT);
    mid_reset();
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    // reset pulsed mid-drain
    cyc(0, 0, 0, 0, 1, 1, V_STALL);
    cyc(0, 0, 0, 0, 0, 0, V_DRAIN);
    mid_reset();
    cyc(0, 0, 0, 0, 0, 0, V_RUN);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);
    cyc(0, 0, 1, 0, 0, 0, V_STALL);
    cyc(0, 0, 0, 0, 0, 0, V_RUN);

    chk_en = 1'b0;
    lit_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 3, width of the stall/flush countdown and of flush_amt.
REQ-002 Parameter DRAIN_CYC, default 3, cycles needed to drain MEM/WB after a serializing instruction (syscall).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mispredict  input  1  branch/jump resolved wrong in EX this cycle.
REQ-006 flush_amt  input  CNT_W  number of wrong-path cycles to squash, sampled with mispredict.
REQ-007 load_use  input  1  instruction in ID needs a load result now in EX.
REQ-008 mem_busy  input  1  data memory multicycle access outstanding.
REQ-009 syscall_ex  input  1  serializing instruction in EX.
REQ-010 halt_req  input  1  syscall in EX requests halt.
REQ-011 if_en, id_en, ex_en, mem_en, wb_en  output  1 each  pipeline register enables.
REQ-012 id_kill  output  1  load nop into ID/EX register; ex_kill  output  1  load nop into EX/MEM register.
REQ-013 flush  output  1  squash countdown active; drives the branch-check flush input.
REQ-014 halted  output  1  pipeline stopped; state_o  output  3  current FSM state (debug).

Function
REQ-015 FSM states: RUN, FLUSH, DRAIN, HALT; outputs are combinational from state, counter and inputs.
REQ-016 RUN, no events: all five enables 1, id_kill/ex_kill/flush/halted 0.
REQ-017 mem_busy=1 in any state except HALT: all five enables 0, kills 0, state and counter hold; overrides every other input.
REQ-018 RUN, mispredict=1, mem_busy=0: same cycle id_kill=1, if_en=1; counter loads max(flush_amt,1); next state FLUSH.
REQ-019 FLUSH: flush=1, id_kill=1, all enables 1; counter decrements each unfrozen cycle; counter==1 -> RUN next cycle.
REQ-020 Mispredict in FLUSH or DRAIN is ignored (wrong-path EX cannot resolve).
REQ-021 RUN, load_use=1, no mispredict, mem_busy=0: if_en=id_en=0, ex_kill=1 for exactly that cycle; no state change.
REQ-022 Priority in RUN: mem_busy > mispredict > syscall_ex > load_use.
REQ-023 RUN, syscall_ex=1: counter loads DRAIN_CYC, halt_req latched, next state DRAIN; if_en=id_en=0, ex_kill=1 that cycle.
REQ-024 DRAIN: if_en=id_en=ex_en=0, mem_en=wb_en=1, ex_kill=1; counter decrements; at counter==1 go HALT if latched halt_req else RUN.
REQ-025 HALT: all enables 0, halted=1; exits only via rst.
REQ-026 Counter arithmetic unsigned CNT_W bits; never decrements below 0; flush_amt=0 treated as 1.
REQ-027 state_o encoding: RUN=0, FLUSH=1, DRAIN=2, HALT=3.

Reset
REQ-028 rst asserted, any state (including mid-FLUSH/DRAIN): state RUN, counter 0, halt latch 0 immediately, without waiting for clk.
REQ-029 Outputs with rst high and inputs idle: enables 1, kills 0, flush 0, halted 0, state_o 0.

Structure
REQ-030 Shared package pipe_ctrl_pkg holds the state enum and DRAIN_CYC/CNT_W defaults.
REQ-031 One sub-module cntdown_reg: loadable, enable-gated CNT_W down-counter with async reset and zero flag.

Verification
REQ-032 mispredict=1, flush_amt=2 in RUN -> id_kill 1 for 3 cycles (entry + 2 FLUSH), flush 1 for 2, RUN on cycle 3.
REQ-033 load_use=1 one cycle -> if_en=id_en=0, ex_kill=1 that cycle only; mispredict+load_use same cycle -> mispredict path, ex_kill=0.
REQ-034 mem_busy=1 for 4 cycles during FLUSH counter=2 -> all enables 0, counter stays 2, FLUSH resumes after.
REQ-035 syscall_ex=1, halt_req=1 -> 3 DRAIN cycles (mem_en=wb_en=1), then halted=1, enables 0 indefinitely; halt_req=0 -> back to RUN.
REQ-036 rst pulsed mid-DRAIN between clock edges -> state_o=0, halted=0, enables 1 before next edge.
REQ-037 mispredict with flush_amt=0 -> behaves as flush_amt=1 (one FLUSH cycle).
